// File: rtl/systolic_pkg.sv
// systolic_pkg: shared defaults, element type and width helpers for the systolic output path.
package systolic_pkg;
    localparam int DEFAULT_ROWS = 3;
    localparam int DEFAULT_COLS = 3;
    localparam int DEFAULT_WORD_SIZE = 16;
    typedef logic [DEFAULT_WORD_SIZE-1:0] word_t;
    // Pointers carry one extra wrap bit so full and empty are distinguishable.
    function automatic int ptr_w(input int depth);
        return $clog2(depth) + 1;
    endfunction
    function automatic int idx_w(input int n);
        return n > 1 ? $clog2(n) : 1;
    endfunction
endpackage

// File: rtl/systolic_output_deskew_if.sv
// systolic_output_deskew_if: skewed column input plus realigned row output handshake.
interface systolic_output_deskew_if
    import systolic_pkg::*;
#(
    parameter int ROWS = DEFAULT_ROWS,
    parameter int COLS = DEFAULT_COLS,
    parameter int WORD_SIZE = DEFAULT_WORD_SIZE
);
    logic [COLS*WORD_SIZE-1:0] bottom_in;
    logic [COLS-1:0] col_valid;
    logic [COLS*WORD_SIZE-1:0] out_row;
    logic out_valid;
    logic out_ready;
    logic [idx_w(ROWS)-1:0] out_row_idx;
    logic out_last;
    modport master (output bottom_in, col_valid, out_ready, input out_row, out_valid, out_row_idx, out_last);
    modport slave (input bottom_in, col_valid, out_ready, output out_row, out_valid, out_row_idx, out_last);
endinterface

// File: rtl/systolic_output_deskew_row_ram.sv
// deskew_row_ram: DEPTH x COLS word store, independent write port per column, one whole-row read port.
module deskew_row_ram #(
    parameter int DEPTH = 4,
    parameter int COLS = 3,
    parameter int WORD_SIZE = 16
) (
    input  logic clk,
    input  logic [COLS-1:0] we,
    input  logic [COLS*$clog2(DEPTH)-1:0] waddr,
    input  logic [COLS*WORD_SIZE-1:0] wdata,
    input  logic [$clog2(DEPTH)-1:0] raddr,
    output logic [COLS*WORD_SIZE-1:0] rdata
);
    localparam int AW = $clog2(DEPTH);
    for (genvar c = 0; c < COLS; c++) begin : g_col
        logic [WORD_SIZE-1:0] mem [DEPTH];
        always_ff @(posedge clk)
            if (we[c]) mem[waddr[c*AW +: AW]] <= wdata[c*WORD_SIZE +: WORD_SIZE];
        assign rdata[c*WORD_SIZE +: WORD_SIZE] = mem[raddr];
    end
endmodule

// File: rtl/systolic_output_deskew.sv
// systolic_output_deskew: realigns skewed systolic column outputs into whole rows with valid/ready output.
// Optional DESKEW_SKEW_CHECK_EN adds a sticky skew_err checker on the column arrival order.
module systolic_output_deskew
    import systolic_pkg::*;
#(
    parameter int ROWS = DEFAULT_ROWS,
    parameter int COLS = DEFAULT_COLS,
    parameter int WORD_SIZE = DEFAULT_WORD_SIZE,
    parameter int DEPTH = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    systolic_output_deskew_if.slave bus,
    output logic [ptr_w(DEPTH)-1:0] occupancy,
    output logic overflow,
    output logic skew_err
);
    localparam int AW = $clog2(DEPTH);
    localparam int PW = ptr_w(DEPTH);
    localparam int IW = idx_w(ROWS);
    logic [PW-1:0] wr_ptr [COLS];
    logic [PW-1:0] rd_ptr;
    logic [AW-1:0] rd_a;
    logic [COLS-1:0] fill [DEPTH];
    logic [COLS-1:0] fill_n [DEPTH];
    logic [COLS-1:0] full, wr;
    logic [COLS*AW-1:0] waddr;
    logic [COLS*WORD_SIZE-1:0] rdata;
    logic [IW-1:0] row_idx;
    logic head, pop, drop;
    assign rd_a = rd_ptr[AW-1:0];
    assign head = &fill[rd_a];
    assign pop = head & bus.out_ready;
    assign drop = |(bus.col_valid & full) & ~pop;
    // A full column may still write when the head pops, since that frees exactly its slot.
    always_comb begin
        full = '0;
        wr = '0;
        waddr = '0;
        occupancy = '0;
        for (int c = 0; c < COLS; c++) begin
            full[c] = (wr_ptr[c] - rd_ptr) == PW'(DEPTH);
            wr[c] = bus.col_valid[c] & (~full[c] | pop);
            waddr[c*AW +: AW] = wr_ptr[c][AW-1:0];
        end
        for (int s = 0; s < DEPTH; s++) begin
            for (int c = 0; c < COLS; c++)
                fill_n[s][c] = (fill[s][c] & ~(pop && rd_a == AW'(s))) | (wr[c] && waddr[c*AW +: AW] == AW'(s));
            occupancy = occupancy + PW'(|fill[s]);
        end
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst || clr) begin
            for (int c = 0; c < COLS; c++) wr_ptr[c] <= '0;
            for (int s = 0; s < DEPTH; s++) fill[s] <= '0;
            rd_ptr <= '0;
            row_idx <= '0;
            overflow <= 1'b0;
        end else begin
            for (int c = 0; c < COLS; c++) if (wr[c]) wr_ptr[c] <= wr_ptr[c] + 1'b1;
            for (int s = 0; s < DEPTH; s++) fill[s] <= fill_n[s];
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
                row_idx <= (row_idx == IW'(ROWS - 1)) ? '0 : row_idx + 1'b1;
            end
            overflow <= overflow | drop;
        end
    end
    deskew_row_ram #(.DEPTH(DEPTH), .COLS(COLS), .WORD_SIZE(WORD_SIZE)) u_ram (
        .clk(clk),
        .we(wr),
        .waddr(waddr),
        .wdata(bus.bottom_in),
        .raddr(rd_a),
        .rdata(rdata)
    );
    assign bus.out_valid = head;
    assign bus.out_row = head ? rdata : '0;
    assign bus.out_row_idx = row_idx;
    assign bus.out_last = head && row_idx == IW'(ROWS - 1);
`ifdef DESKEW_SKEW_CHECK_EN
    // Column c may only fire one cycle after column c-1 did.
    logic [COLS-2:0] prev_cv;
    always_ff @(posedge clk or posedge rst) begin
        if (rst || clr) begin
            prev_cv <= '0;
            skew_err <= 1'b0;
        end else begin
            prev_cv <= bus.col_valid[COLS-2:0];
            skew_err <= skew_err | |(bus.col_valid[COLS-1:1] & ~prev_cv);
        end
    end
`else
    assign skew_err = 1'b0;
`endif
endmodule
